// File: rtl/nx_fifo_pkg.sv
// Shared constants for the nx_fifo read-side blocks: latency bound, level width
// and a pointer-wrap helper for the small skid buffers.
package nx_fifo_pkg;

    localparam int NX_FIFO_RD_LAT_MAX = 2;
    localparam int NX_FIFO_LVL_W      = 3;
    localparam int NX_FIFO_PTR_W      = $clog2(NX_FIFO_RD_LAT_MAX + 2);

    // Advance a circular-buffer pointer, wrapping at an arbitrary (non power of two) depth.
    function automatic logic [NX_FIFO_PTR_W-1:0] nx_ptr_inc(
        input logic [NX_FIFO_PTR_W-1:0] ptr,
        input int                       depth
    );
        return (int'(ptr) == depth - 1) ? '0 : ptr + NX_FIFO_PTR_W'(1);
    endfunction

endpackage

// File: rtl/nx_fifo_rd_skid.sv
// DEPTH-entry circular skid buffer: storage, pointers and occupancy count.
// clear wins over a simultaneous write or pop; storage contents survive a clear.
module nx_fifo_rd_skid
    import nx_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        rd_data,
    output logic [NX_FIFO_LVL_W-1:0] cnt
);

    logic [DATA_W-1:0]        mem [DEPTH];
    logic [NX_FIFO_PTR_W-1:0] wr_ptr;
    logic [NX_FIFO_PTR_W-1:0] rd_ptr;
    logic                     do_wr;
    logic                     do_pop;

    assign do_wr   = wr_en && !clear;
    assign do_pop  = pop && !clear;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= nx_ptr_inc(wr_ptr, DEPTH);
            end
            if (do_pop) begin
                rd_ptr <= nx_ptr_inc(rd_ptr, DEPTH);
            end
            case ({do_wr, do_pop})
                2'b10:   cnt <= cnt + NX_FIFO_LVL_W'(1);
                2'b01:   cnt <= cnt - NX_FIFO_LVL_W'(1);
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/nx_fifo_rd_stage.sv
// Read stage for an nx_fifo_ctrl + synchronous RAM pair: credit-based fifo_ren,
// RD_LAT in-flight pipe and a skid buffer. Optional SVA: NX_FIFO_RD_STAGE_ASSERT_EN.
module nx_fifo_rd_stage
    import nx_fifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fifo_empty,
    output logic                     fifo_ren,
    input  logic [DATA_W-1:0]        ram_rdata,
    input  logic                     clear,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [NX_FIFO_LVL_W-1:0] level
);

    localparam int                       DEPTH     = RD_LAT + 2;
    localparam logic [NX_FIFO_LVL_W-1:0] DEPTH_LVL = NX_FIFO_LVL_W'(DEPTH);

    logic [RD_LAT-1:0]        inflight_pipe;
    logic [NX_FIFO_LVL_W-1:0] cnt;
    logic                     wr_en;
    logic                     pop;

    // out_valid/out_ready: a word transfers on every edge where both are high;
    // out_valid never depends on out_ready, and out_data holds while stalled.
    // level counts reads already issued, so out_ready never reaches fifo_ren.
    assign fifo_ren  = !fifo_empty && !clear && (level < DEPTH_LVL);
    assign out_valid = (cnt != '0);
    assign pop       = out_valid && out_ready && !clear;
    assign wr_en     = inflight_pipe[RD_LAT-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_pipe <= '0;
        end else if (clear) begin
            inflight_pipe <= '0;
        end else begin
            inflight_pipe[0] <= fifo_ren;
            for (int i = 1; i < RD_LAT; i++) begin
                inflight_pipe[i] <= inflight_pipe[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level <= '0;
        end else if (clear) begin
            level <= '0;
        end else begin
            case ({fifo_ren, pop})
                2'b10:   level <= level + NX_FIFO_LVL_W'(1);
                2'b01:   level <= level - NX_FIFO_LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    nx_fifo_rd_skid #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_skid (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (clear),
        .wr_en   (wr_en),
        .wr_data (ram_rdata),
        .pop     (pop),
        .rd_data (out_data),
        .cnt     (cnt)
    );

`ifdef NX_FIFO_RD_STAGE_ASSERT_EN
    a_ren_not_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(fifo_ren && fifo_empty));

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(wr_en && !clear && (cnt == DEPTH_LVL)));

    a_stall_stable: assert property (@(posedge clk) disable iff (!rst_n)
        (out_valid && !out_ready && !clear) |=> $stable(out_data));

    c_level_full: cover property (@(posedge clk) disable iff (!rst_n)
        level == DEPTH_LVL);

    c_level_drained: cover property (@(posedge clk) disable iff (!rst_n)
        ($past(level) != '0) && (level == '0));
`endif

endmodule

// File: tb/tb_nx_fifo_rd_stage.sv
// Bench for nx_fifo_rd_stage: one instance per read latency (1 and 2), a queue
// model of the upstream FIFO/RAM and a transaction-level scoreboard.
module tb_nx_fifo_rd_stage;

    localparam int W = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    logic         fifo_empty [2];
    logic         fifo_ren   [2];
    logic [W-1:0] ram_rdata  [2];
    logic         clear      [2];
    logic         out_valid  [2];
    logic         out_ready  [2];
    logic [W-1:0] out_data   [2];
    logic [2:0]   level      [2];

    for (genvar g = 0; g < 2; g++) begin : g_dut
        nx_fifo_rd_stage #(
            .DATA_W (W),
            .RD_LAT (g + 1)
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .fifo_empty (fifo_empty[g]),
            .fifo_ren   (fifo_ren[g]),
            .ram_rdata  (ram_rdata[g]),
            .clear      (clear[g]),
            .out_valid  (out_valid[g]),
            .out_ready  (out_ready[g]),
            .out_data   (out_data[g]),
            .level      (level[g])
        );
    end

    // ---------------- model state / scoreboard ----------------
    logic [W-1:0] exp_q   [2][$];   // words issued and not yet consumed, in order
    int           rdy_q   [2][$];   // first cycle each expected word may be presented
    logic [W-1:0] src_q   [2][$];   // words still held by the upstream FIFO
    logic [W-1:0] pop_log [2][$];
    int           pop_cyc [2][$];
    logic [W-1:0] lat     [2][2];
    logic         hold_empty [2];

    int cyc;
    int n_chk, n_pass, n_fail;
    int ren_cnt [2], ren_run [2], ren_run_max [2], valid_cnt [2];
    logic         s_ren [2], s_valid [2];
    logic [W-1:0] s_data [2];
    logic [2:0]   s_level [2];

    function automatic int depth(input int k);
        return k + 3;
    endfunction

    function automatic int rdl(input int k);
        return k + 1;
    endfunction

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd_inputs();
        for (int k = 0; k < 2; k++) begin
            fifo_empty[k] = hold_empty[k] || (src_q[k].size() == 0);
        end
    endtask

    task automatic clr_stats();
        for (int k = 0; k < 2; k++) begin
            ren_cnt[k] = 0;
            ren_run[k] = 0;
            ren_run_max[k] = 0;
            valid_cnt[k] = 0;
            pop_log[k].delete();
            pop_cyc[k].delete();
        end
    endtask

    // One clock cycle: check both DUTs at the falling edge, advance the model after the rising edge.
    task automatic tick();
        logic         e_ren [2];
        logic         e_pop [2];
        logic         e_valid;
        logic [W-1:0] w;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            s_ren[k]   = fifo_ren[k];
            s_valid[k] = out_valid[k];
            s_data[k]  = out_data[k];
            s_level[k] = level[k];
            e_ren[k] = !fifo_empty[k] && !clear[k] && (exp_q[k].size() < depth(k));
            e_valid  = 1'b0;
            if (exp_q[k].size() > 0) begin
                e_valid = (rdy_q[k][0] <= cyc);
            end
            chk($sformatf("ren[%0d]@%0d", k, cyc), W'(fifo_ren[k]), W'(e_ren[k]));
            chk($sformatf("level[%0d]@%0d", k, cyc), W'(level[k]), W'(exp_q[k].size()));
            chk($sformatf("valid[%0d]@%0d", k, cyc), W'(out_valid[k]), W'(e_valid));
            if (e_valid) begin
                chk($sformatf("data[%0d]@%0d", k, cyc), out_data[k], exp_q[k][0]);
            end
            e_pop[k] = e_valid && out_ready[k] && !clear[k];
            if (e_pop[k]) begin
                pop_log[k].push_back(out_data[k]);
                pop_cyc[k].push_back(cyc);
            end
            if (fifo_ren[k]) begin
                ren_cnt[k]++;
                ren_run[k]++;
                if (ren_run[k] > ren_run_max[k]) ren_run_max[k] = ren_run[k];
            end else begin
                ren_run[k] = 0;
            end
            if (out_valid[k]) valid_cnt[k]++;
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            w = $urandom();
            if (clear[k]) begin
                exp_q[k].delete();
                rdy_q[k].delete();
                src_q[k].delete();
            end else begin
                if (e_pop[k]) begin
                    exp_q[k].delete(0);
                    rdy_q[k].delete(0);
                end
                if (e_ren[k]) begin
                    w = src_q[k].pop_front();
                    exp_q[k].push_back(w);
                    rdy_q[k].push_back(cyc + rdl(k) + 1);
                end
            end
            lat[k][1] = lat[k][0];
            lat[k][0] = w;
            ram_rdata[k] = lat[k][rdl(k) - 1];
        end
        cyc++;
        upd_inputs();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic push_words(input int k, input int n, input logic [W-1:0] base, input bit rnd);
        for (int i = 0; i < n; i++) begin
            src_q[k].push_back(rnd ? W'($urandom()) : base + W'(i));
        end
        upd_inputs();
    endtask

    task automatic drain(input int k);
        int guard;
        guard = 0;
        hold_empty[k] = 1'b0;
        out_ready[k]  = 1'b1;
        upd_inputs();
        while ((exp_q[k].size() != 0 || src_q[k].size() != 0) && guard < 200) begin
            tick();
            guard++;
        end
        chk($sformatf("drain[%0d]", k), W'(exp_q[k].size() + src_q[k].size()), '0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            exp_q[k].delete();
            rdy_q[k].delete();
            src_q[k].delete();
            lat[k][0] = '0;
            lat[k][1] = '0;
            ram_rdata[k] = '0;
            clear[k] = 1'b0;
            out_ready[k] = 1'b0;
            hold_empty[k] = 1'b1;
        end
        upd_inputs();
    endtask

    task automatic chk_order(input int k, input string tag, input int n, input logic [W-1:0] base);
        chk({tag, "_count"}, W'(pop_log[k].size()), W'(n));
        for (int i = 0; i < n && i < pop_log[k].size(); i++) begin
            chk($sformatf("%s_word%0d", tag, i), pop_log[k][i], base + W'(i));
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed + random sequence ----------------
    initial begin
        n_chk = 0;
        n_pass = 0;
        n_fail = 0;
        cyc = 0;
        rst_n = 1'b0;
        model_reset();
        clr_stats();
        #12;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ren[%0d]", k), W'(fifo_ren[k]), '0);
            chk($sformatf("rst_valid[%0d]", k), W'(out_valid[k]), '0);
            chk($sformatf("rst_data[%0d]", k), out_data[k], '0);
            chk($sformatf("rst_level[%0d]", k), W'(level[k]), '0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        hold_empty[0] = 1'b0;
        hold_empty[1] = 1'b0;
        upd_inputs();

        // First word, RD_LAT=1: empty drops at cycle 5, data out at cycle 7.
        run(5);
        push_words(0, 1, 32'hA5A5_0001, 1'b0);
        tick();
        chk("t1_ren_c5", W'(s_ren[0]), 1);
        chk("t1_ren_before", W'(ren_cnt[0]), 1);
        tick();
        chk("t1_valid_c6", W'(s_valid[0]), 0);
        tick();
        chk("t1_valid_c7", W'(s_valid[0]), 1);
        chk("t1_data_c7", s_data[0], 32'hA5A5_0001);
        drain(0);

        // Streaming 16 words at full rate on both latencies.
        for (int k = 0; k < 2; k++) begin
            clr_stats();
            out_ready[k] = 1'b1;
            push_words(k, 16, 32'd0, 1'b0);
            run(25);
            chk($sformatf("t2_ren_run[%0d]", k), W'(ren_run_max[k]), 16);
            chk($sformatf("t2_ren_cnt[%0d]", k), W'(ren_cnt[k]), 16);
            chk_order(k, $sformatf("t2_stream%0d", k), 16, 32'd0);
            if (pop_cyc[k].size() == 16) begin
                chk($sformatf("t2_gapless[%0d]", k), W'(pop_cyc[k][15] - pop_cyc[k][0]), 15);
            end
        end

        // Backpressure, RD_LAT=2: four reads then stall with word 0 at the head.
        clr_stats();
        out_ready[1] = 1'b0;
        push_words(1, 10, 32'd0, 1'b0);
        run(12);
        chk("t3_ren_pulses", W'(ren_cnt[1]), 4);
        chk("t3_level", W'(s_level[1]), 4);
        chk("t3_valid", W'(s_valid[1]), 1);
        chk("t3_head", s_data[1], 32'd0);
        drain(1);
        chk_order(1, "t3_release", 10, 32'd0);

        // Clear one cycle after a read with RD_LAT=2: returning word is dropped.
        clr_stats();
        out_ready[1] = 1'b0;
        push_words(1, 4, 32'hC000, 1'b0);
        tick();
        chk("t4_ren", W'(s_ren[1]), 1);
        hold_empty[1] = 1'b1;
        clear[1] = 1'b1;
        upd_inputs();
        tick();
        chk("t4_ren_in_clear", W'(s_ren[1]), 0);
        chk("t4_level_in_clear", W'(s_level[1]), 1);
        clear[1] = 1'b0;
        tick();
        chk("t4_level_after", W'(s_level[1]), 0);
        chk("t4_valid_after", W'(s_valid[1]), 0);
        clr_stats();
        run(6);
        chk("t4_no_ghost", W'(valid_cnt[1]), 0);

        // Empty boundary: 50 cycles of empty with a ready consumer.
        clr_stats();
        for (int k = 0; k < 2; k++) begin
            hold_empty[k] = 1'b1;
            out_ready[k] = 1'b1;
        end
        upd_inputs();
        run(50);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("t5_no_ren[%0d]", k), W'(ren_cnt[k]), 0);
            chk($sformatf("t5_no_valid[%0d]", k), W'(valid_cnt[k]), 0);
            hold_empty[k] = 1'b0;
        end
        upd_inputs();

        // Wrap-around: alternating ready over 3*DEPTH words.
        for (int k = 0; k < 2; k++) begin
            int guard;
            clr_stats();
            push_words(k, 3 * depth(k), 32'h100, 1'b0);
            guard = 0;
            while ((exp_q[k].size() != 0 || src_q[k].size() != 0) && guard < 200) begin
                out_ready[k] = guard[0];
                tick();
                guard++;
            end
            chk_order(k, $sformatf("t6_wrap%0d", k), 3 * depth(k), 32'h100);
        end

        // Randomized traffic on both instances, including random clears.
        clr_stats();
        for (int n = 0; n < 400; n++) begin
            for (int k = 0; k < 2; k++) begin
                out_ready[k]  = ($urandom_range(0, 3) != 0);
                hold_empty[k] = ($urandom_range(0, 7) == 0);
                clear[k]      = ($urandom_range(0, 49) == 0);
                if (src_q[k].size() < 6 && $urandom_range(0, 1) == 1) begin
                    src_q[k].push_back(W'($urandom()));
                end
            end
            upd_inputs();
            tick();
        end
        clear[0] = 1'b0;
        clear[1] = 1'b0;
        drain(0);
        drain(1);

        // Asynchronous reset in the middle of a stream.
        clr_stats();
        push_words(0, 8, 32'h0, 1'b1);
        out_ready[0] = 1'b1;
        run(4);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t8_valid0", W'(out_valid[0]), 0);
        chk("t8_level0", W'(level[0]), 0);
        chk("t8_data0", out_data[0], '0);
        chk("t8_valid1", W'(out_valid[1]), 0);
        model_reset();
        #1;
        chk("t8_ren0", W'(fifo_ren[0]), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        cyc = 0;
        hold_empty[0] = 1'b0;
        hold_empty[1] = 1'b0;
        clr_stats();
        push_words(0, 4, 32'h200, 1'b0);
        drain(0);
        chk_order(0, "t8_restart", 4, 32'h200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/nx_fifo_rd_stage.md
# nx_fifo_rd_stage

Read-side companion to the `nx_fifo_ctrl` family: drains a FIFO controller plus its synchronous RAM and presents the data as a valid/ready stream. It issues `ren` against the controller's `empty` flag and absorbs the RAM's fixed read latency in a small credit-managed skid buffer. The result is full throughput with no combinational path from `out_ready` back to `fifo_ren`. It sits between any `nx_fifo_ctrl` + RAM pair and the downstream consumer.

## Interface
Parameters:
- `DATA_W`, 32 — payload width.
- `RD_LAT`, 1 — RAM read latency in cycles; legal values are 1 or 2.
- `DEPTH` (localparam) = `RD_LAT` + 2 — number of skid-buffer entries.

Ports:
- `clk`  in  1  — single clock for the block.
- `rst_n`  in  1  — reset; asynchronous, active-low.
- `fifo_empty`  in  1  — registered `empty` from the FIFO controller.
- `fifo_ren`  out  1  — read enable to the controller, which also drives the RAM read.
- `ram_rdata`  in  `DATA_W`  — RAM read data, valid exactly `RD_LAT` cycles after `fifo_ren`.
- `clear`  in  1  — synchronous flush; asserted in the same cycle as the controller's `clear`.
- `out_valid`  out  1  — downstream data valid.
- `out_ready`  in  1  — downstream accept.
- `out_data`  out  `DATA_W`  — head-of-buffer data.
- `level`  out  3  — in-flight reads plus buffered entries, range 0..`DEPTH`.

## Operation
- **In-flight tracking:** an `RD_LAT`-deep shift register of valid bits, `inflight_pipe`. Bit 0 loads `fifo_ren`; the last stage marks `ram_rdata` as valid.
- **Buffer:** `DEPTH` entries, organised as a circular buffer with `wr_ptr`, `rd_ptr` and `cnt`.
- **Write:** when the last pipe stage is 1, `ram_rdata` is written at `wr_ptr`; `wr_ptr` wraps modulo `DEPTH`.
- **Pop:** a pop occurs when `out_valid` and `out_ready` are both high. `rd_ptr` advances with wrap modulo `DEPTH`.
- **Outputs:** `out_valid` = (`cnt` != 0). `out_data` = `buf[rd_ptr]`.
- **Credit rule:** `fifo_ren` = `!fifo_empty` && `!clear` && (`level` < `DEPTH`).
  - `level` is the registered sum of set pipe bits plus `cnt`.
  - No pop credit is taken in the same cycle; this keeps `out_ready` off the `fifo_ren` path.
- **Counter update:** `level` increments on `fifo_ren` and decrements on a pop. Simultaneous increment and decrement leaves it unchanged. `cnt` updates the same way from write and pop.
- **Clear:** zeroes the pipe, `cnt`, `level` and both pointers on the next edge. Data returning from the RAM for pre-clear reads is discarded. Buffer contents are not zeroed.
- **Overflow safety:** by construction a write never arrives when `cnt` == `DEPTH`.
- **No upstream error flags:** the block never produces overflow or underflow conditions on the controller, because `fifo_ren` is never high while `fifo_empty` is high.

## Timing
- **Reset values:** `fifo_ren`=0, `out_valid`=0, `out_data`=0 (buffer storage resets to 0), `level`=0. All pointers and pipe bits reset to 0.
- **First-word latency:**
  - Cycle 0: `fifo_empty` falls and `fifo_ren`=1.
  - Cycle `RD_LAT`: data is captured.
  - Cycle `RD_LAT`+1: `out_valid`=1.
  - Total: `RD_LAT`+1 cycles.
- **Throughput:** sustained 1 word/cycle whenever `out_ready` is held high and the FIFO stays non-empty.
- **Stall and stability:** with `out_ready`=0 the buffer fills. `fifo_ren` stops when `level` reaches `DEPTH`. `out_data` and `out_valid` hold stable while `out_valid`=1 and `out_ready`=0.
- **Clear cycle:** `fifo_ren`=0 in the `clear` cycle. `out_valid`=0 from the next cycle.
- **Clear with pop:** `clear` takes priority over a simultaneous pop or write.
- **Reset mid-transfer:** asynchronous; all state returns to the reset values immediately.

## Configuration
- **`NX_FIFO_RD_STAGE_ASSERT_EN` defined:** the block compiles in the following SVA.
  - Assertion: `fifo_ren` is never high with `fifo_empty`.
  - Assertion: a buffer write never occurs with `cnt`==`DEPTH`.
  - Assertion: `out_data` is stable while `out_valid` && !`out_ready`.
  - Cover: `level`==`DEPTH`.
  - Cover: `level`==0 after non-zero.
- **Macro undefined:** no assertion or cover logic is present. Functional behaviour is identical in both cases.

## Structure
- **Shared package `nx_fifo_pkg`:**
  - constant `NX_FIFO_RD_LAT_MAX` = 2;
  - the `level` width `NX_FIFO_LVL_W` = 3.
- **Sub-module:** one natural sub-module, `nx_fifo_rd_skid`. It holds the `DEPTH`-entry circular buffer: storage, pointers, `cnt`, and the write/pop ports. The top level holds the credit logic and the in-flight pipe.

## Test plan
- **Reset and first word:** `RD_LAT`=1; release reset; drop `fifo_empty` at cycle 5 with `ram_rdata`=0xA5A5_0001 one cycle later. Required: `fifo_ren` high at cycle 5; `out_valid` and `out_data`=0xA5A5_0001 at cycle 7.
- **Streaming:** stream 16 words 0..15 with `out_ready`=1 and `fifo_empty`=0. Required: `fifo_ren` high 16 consecutive cycles; `out_data` sequence 0..15 with no gaps.
- **Backpressure:** `out_ready`=0 and FIFO non-empty, `RD_LAT`=2. Required: exactly 4 `fifo_ren` pulses; `level`=4; `out_data` holds word 0. Then raise `out_ready`: words 0..3 emerge in order, none dropped.
- **Clear with reads in flight:** assert `clear` one cycle after a `fifo_ren` with `RD_LAT`=2. Required: the returning word is discarded; `level`=0 and `out_valid`=0 on the next cycle.
- **Empty boundary:** hold `fifo_empty`=1 for 50 cycles with `out_ready`=1. Required: `fifo_ren` never asserts; `out_valid` stays 0.
- **Wrap-around:** pop and push alternating over 3×`DEPTH` words (values 0x100+i). Required: output order is preserved across pointer wrap.
